// File: rtl/ddr_axi_pkg.sv
// Shared types and constants for the DDR controller AXI read path.
package ddr_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } rd_state_t;

  // One accepted AR burst: beats-minus-one and its decode-error flag.
  typedef struct packed {
    logic [7:0] len;
    logic       err;
  } rq_entry_t;

endpackage

// File: rtl/rd_len_queue.sv
// Queue of accepted-but-unfinished read bursts. Head is visible without a pop
// so the read FSM can steer on head.err and count beats against head.len.
module rd_len_queue
  import ddr_axi_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  rq_entry_t       push_data,
  input  logic            pop,
  output rq_entry_t       head,
  output logic [CW-1:0]   qcount,
  output logic            empty,
  output logic            full
);

  localparam logic [CW-1:0] DEPTH_Q = CW'(DEPTH);

  rq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (qcount == '0);
  assign full    = (qcount == DEPTH_Q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop leave qcount unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      qcount <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   qcount <= qcount + 1'b1;
        2'b01:   qcount <= qcount - 1'b1;
        default: qcount <= qcount;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/read_fsm.sv
// AXI read-channel slave controller (AR/R) for the DDR controller.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; once RVALID is raised, RVALID/RLAST/RRESP hold until RREADY.
// Decode-error bursts are answered with SLVERR beats and never reach DDR.
module read_fsm
  import ddr_axi_pkg::*;
#(
  parameter int MAX_TRANSACTIONS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ARVALID,
  input  logic [7:0] ARLEN,
  input  logic       err,
  input  logic [3:0] num_transactions,
  input  logic       rd_ack,
  input  logic       rempty,
  input  logic       RREADY,
  output logic       ARREADY,
  output logic       load,
  output logic       rd_req,
  output logic       rdata_pop,
  output logic       RVALID,
  output logic       RLAST,
  output logic [1:0] RRESP,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(MAX_TRANSACTIONS) + 1;
  localparam logic [CW-1:0] MAX_Q = CW'(MAX_TRANSACTIONS);
  localparam logic [3:0]    MAX_N = 4'(MAX_TRANSACTIONS);

  rd_state_t       state;
  rd_state_t       next_state;
  logic [7:0]      beat_cnt;
  logic            next_arready;
  logic            r_hs;
  logic            q_pop;
  logic            q_push;
  logic            q_empty;
  logic            q_full;
  logic [CW-1:0]   qcount;
  rq_entry_t       head;
  rq_entry_t       push_entry;

  assign load         = ARVALID && ARREADY;
  assign q_push       = load && !q_full;
  assign push_entry   = '{len: ARLEN, err: err};
  // Dropping ARREADY right after an accept gives qcount time to update first.
  assign next_arready = !load && (qcount < MAX_Q) && (num_transactions < MAX_N);
  assign dbg_state    = state;

  rd_len_queue #(.DEPTH(MAX_TRANSACTIONS)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (q_pop),
    .head      (head),
    .qcount    (qcount),
    .empty     (q_empty),
    .full      (q_full)
  );

  // Registered ARREADY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ARREADY <= 1'b0;
    else     ARREADY <= next_arready;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Beat counter: cleared before each burst, advanced on every R handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                beat_cnt <= 8'd0;
    else if (state == IDLE || state == REQ) beat_cnt <= 8'd0;
    else if (r_hs)                          beat_cnt <= beat_cnt + 8'd1;
  end

  // Next-state and R-channel outputs, all decoded from state and head entry.
  always_comb begin
    next_state = state;
    rd_req     = 1'b0;
    RVALID     = 1'b0;
    RLAST      = 1'b0;
    RRESP      = RESP_OKAY;
    rdata_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) next_state = head.err ? ERR : REQ;
      end
      REQ: begin
        rd_req = 1'b1;
        if (rd_ack) next_state = DATA;
      end
      DATA: begin
        RVALID    = !rempty;
        RLAST     = (beat_cnt == head.len);
        rdata_pop = RVALID && RREADY;
        if (rdata_pop && RLAST) next_state = IDLE;
      end
      ERR: begin
        RVALID = 1'b1;
        RRESP  = RESP_SLVERR;
        RLAST  = (beat_cnt == head.len);
        if (RREADY && RLAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    r_hs  = RVALID && RREADY;
    q_pop = r_hs && RLAST;
  end

endmodule

// File: tb/tb_read_fsm.sv
// Bench for read_fsm: AR/R driver tasks, a DDR/read-FIFO model and a
// scoreboard of expected {RLAST, RRESP} per beat.
module tb_read_fsm;
  import ddr_axi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ARVALID;
  logic [7:0] ARLEN;
  logic       err;
  logic [3:0] num_transactions;
  logic       rd_ack;
  logic       rempty;
  logic       RREADY;
  logic       ARREADY;
  logic       load;
  logic       rd_req;
  logic       rdata_pop;
  logic       RVALID;
  logic       RLAST;
  logic [1:0] RRESP;
  logic [1:0] dbg_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  read_fsm #(.MAX_TRANSACTIONS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .ARVALID          (ARVALID),
    .ARLEN            (ARLEN),
    .err              (err),
    .num_transactions (num_transactions),
    .rd_ack           (rd_ack),
    .rempty           (rempty),
    .RREADY           (RREADY),
    .ARREADY          (ARREADY),
    .load             (load),
    .rd_req           (rd_req),
    .rdata_pop        (rdata_pop),
    .RVALID           (RVALID),
    .RLAST            (RLAST),
    .RRESP            (RRESP),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_q[$];
  int         ddr_len_q[$];
  logic [2:0] e;
  int         fifo_words = 0;
  int         pending_words = 0;
  int         req_wait = 0;
  bit         trickle = 1'b0;
  bit         pop_seen = 1'b0;
  int         pop_cnt = 0;
  int         rlast_cnt = 0;
  int         rd_req_cyc = 0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_r = 4'd0;

  assign rempty = (fifo_words == 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- DDR / FIFO model and R monitor ----------------
  initial begin
    rd_ack = 1'b0;
    forever begin
      // Model update just after the edge: FIFO pops, rd_ack, data arrival.
      @(posedge clk); #1;
      if (rst) begin
        fifo_words = 0; pending_words = 0; req_wait = 0; rd_ack = 1'b0;
        ddr_len_q.delete();
      end else begin
        if (pop_seen) fifo_words--;
        if (rd_ack) rd_ack = 1'b0;
        else if (rd_req) begin
          req_wait++;
          if (req_wait == 2) begin
            rd_ack = 1'b1;
            req_wait = 0;
            check("ddr_len_avail", ddr_len_q.size() != 0, 1);
            if (ddr_len_q.size() != 0) pending_words += ddr_len_q.pop_front() + 1;
          end
        end
        if (!trickle) begin
          fifo_words += pending_words;
          pending_words = 0;
        end else if (pending_words > 0 && $urandom_range(0, 1) == 1) begin
          fifo_words++;
          pending_words--;
        end
      end
      // Mid-cycle: observe what the next rising edge will transfer.
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pop_seen = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (rd_req) rd_req_cyc++;
        if (rdata_pop) check("pop_not_empty", rempty, 0);
        pop_seen = rdata_pop;
        if (prev_stall) check("stall_stable", {RVALID, RLAST, RRESP}, prev_r);
        if (ARVALID && ARREADY) begin
          check("load", load, 1);
          for (int i = 0; i <= int'(ARLEN); i++)
            exp_q.push_back({(i == int'(ARLEN)), err ? RESP_SLVERR : RESP_OKAY});
          if (!err) ddr_len_q.push_back(int'(ARLEN));
        end
        if (RVALID && RREADY) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("r_beat", {RLAST, RRESP}, e);
            check("r_pop", rdata_pop, (e[1:0] == RESP_OKAY));
          end
          if (RLAST) rlast_cnt++;
        end
        if (rdata_pop) pop_cnt++;
        prev_stall = RVALID && !RREADY;
        prev_r = {RVALID, RLAST, RRESP};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_ar(input logic [7:0] len, input logic e_in);
    int n = 0;
    @(posedge clk); #1;
    ARVALID = 1'b1; ARLEN = len; err = e_in;
    @(negedge clk);
    while (!ARREADY && n < 200) begin @(negedge clk); n++; end
    check("ar_accept", ARREADY, 1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || dbg_state != 2'd0) && n < budget) begin
      @(negedge clk); n++;
    end
    check(tag, (exp_q.size() == 0 && dbg_state == 2'd0), 1);
  endtask

  task automatic wait_rvalid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!RVALID && n < 100) begin @(negedge clk); n++; end
    check(tag, RVALID, 1);
  endtask

  // ---------------- main sequence ----------------
  int p0, r0, q0;

  initial begin
    rst = 1'b1; ARVALID = 1'b0; ARLEN = 8'd0; err = 1'b0;
    num_transactions = 4'd0; RREADY = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_arready", ARREADY, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_pop", rdata_pop, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // 1: 4-beat OKAY burst, RREADY held high.
    RREADY = 1'b1;
    p0 = pop_cnt; r0 = rlast_cnt; q0 = rd_req_cyc;
    send_ar(8'd3, 1'b0);
    wait_idle("t1_idle", 100);
    check("t1_pops", pop_cnt - p0, 4);
    check("t1_rlast_cnt", rlast_cnt - r0, 1);
    check("t1_rd_req_seen", (rd_req_cyc - q0) > 0, 1);

    // 2: single-beat decode error, no DDR request.
    p0 = pop_cnt; r0 = rlast_cnt; q0 = rd_req_cyc;
    send_ar(8'd0, 1'b1);
    wait_idle("t2_idle", 50);
    check("t2_pops", pop_cnt - p0, 0);
    check("t2_rlast_cnt", rlast_cnt - r0, 1);
    check("t2_no_rd_req", rd_req_cyc - q0, 0);

    // 3: fill the queue with RREADY low, then retire one burst.
    RREADY = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) send_ar(8'd0, 1'b0);
    repeat (3) begin @(negedge clk); check("t3_arready_full", ARREADY, 0); end
    wait_rvalid("t3_rvalid");
    @(posedge clk); #1; RREADY = 1'b1;
    @(posedge clk); #1; RREADY = 1'b0;
    @(negedge clk); check("t3_arready_bubble", ARREADY, 0);
    @(negedge clk); check("t3_arready_rise", ARREADY, 1);
    @(posedge clk); #1; RREADY = 1'b1;
    wait_idle("t3_drain", 400);
    check("t3_pops", pop_cnt - p0, 8);
    @(posedge clk); #1; num_transactions = 4'd8;
    @(negedge clk); @(negedge clk); check("t3_ddr_full_blocks", ARREADY, 0);
    @(posedge clk); #1; num_transactions = 4'd0;
    @(negedge clk); @(negedge clk); check("t3_ddr_free", ARREADY, 1);

    // 4: 8-beat burst with random RREADY and FIFO trickling in.
    trickle = 1'b1;
    p0 = pop_cnt; r0 = rlast_cnt;
    send_ar(8'd7, 1'b0);
    for (int n = 0; n < 400 && (exp_q.size() != 0 || dbg_state != 2'd0); n++) begin
      @(posedge clk); #1;
      RREADY = 1'($urandom_range(0, 1));
    end
    wait_idle("t4_idle", 10);
    check("t4_pops", pop_cnt - p0, 8);
    check("t4_rlast_cnt", rlast_cnt - r0, 1);
    @(posedge clk); #1; RREADY = 1'b1; trickle = 1'b0;

    // 5: AR accepted in the same cycle as the last-beat pop.
    RREADY = 1'b0;
    p0 = pop_cnt;
    send_ar(8'd0, 1'b0);
    wait_rvalid("t5_rvalid");
    @(posedge clk); #1;
    ARVALID = 1'b1; ARLEN = 8'd2; err = 1'b0; RREADY = 1'b1;
    @(negedge clk);
    check("t5_arready", ARREADY, 1);
    check("t5_last_beat", RVALID && RLAST, 1);
    @(posedge clk); #1; ARVALID = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t5_req_next", rd_req, 1);
    wait_idle("t5_idle", 100);
    check("t5_pops", pop_cnt - p0, 4);

    // 6: reset in the middle of a 4-beat burst with a second burst queued.
    RREADY = 1'b0;
    send_ar(8'd3, 1'b0);
    send_ar(8'd0, 1'b1);
    wait_rvalid("t6_rvalid");
    @(posedge clk); #1; RREADY = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; RREADY = 1'b0; rst = 1'b1;
    #1;
    check("t6_rvalid", RVALID, 0);
    check("t6_rlast", RLAST, 0);
    check("t6_rresp", RRESP, 0);
    check("t6_pop", rdata_pop, 0);
    check("t6_rd_req", rd_req, 0);
    check("t6_arready", ARREADY, 0);
    check("t6_state", dbg_state, 0);
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_queue_empty", dbg_state, 0);
    RREADY = 1'b1;
    p0 = pop_cnt; r0 = rlast_cnt;
    send_ar(8'd1, 1'b0);
    wait_idle("t6_idle", 100);
    check("t6_pops", pop_cnt - p0, 2);
    check("t6_rlast_cnt", rlast_cnt - r0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit in case a bounded loop is ever bypassed.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
